// File: rtl/accel_dispatch.sv
// rtl/accel_dispatch.sv - sample FIFO feeding a single-job function accelerator; optional busy counter under ACCEL_DISPATCH_PERF_EN
module accel_dispatch #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic                     in_valid,
   input  logic [31:0]              in_x,
   output logic                     in_ready,
   output logic                     acc_start,
   output logic [31:0]              acc_x,
   input  logic                     acc_done,
   input  logic [31:0]              acc_y,
   output logic                     out_valid,
   output logic [31:0]              out_y,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   in_count,
   output logic                     spurious_done
`ifdef ACCEL_DISPATCH_PERF_EN
   ,
   output logic [31:0]              perf_busy
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_HOLD} state_t;

   state_t        state, state_n;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, capture;

   // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
   always_comb begin
      in_ready = (in_count < (AW+1)'(DEPTH)) & clk_en;
      push     = in_valid & in_ready;
   end

   // State register; reset wins over clock enable.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else if (clk_en)
         state <= state_n;
   end

   // Next-state logic: one job in flight, LAUNCH lasts exactly one enabled cycle.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (in_count != '0) state_n = ST_LAUNCH;
         ST_LAUNCH: state_n = ST_WAIT;
         ST_WAIT:   if (acc_done) state_n = ST_HOLD;
         ST_HOLD:   if (out_ready) state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // FSM outputs and the qualified events that move data.
   always_comb begin
      acc_start = clk_en & (state == ST_LAUNCH);
      out_valid = (state == ST_HOLD);
      pop       = clk_en & (state == ST_IDLE) & (in_count != '0);
      capture   = clk_en & (state == ST_WAIT) & acc_done;
   end

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_x;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         in_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   in_count <= in_count + 1'b1;
            2'b01:   in_count <= in_count - 1'b1;
            default: in_count <= in_count;
         endcase
      end
   end

   // Operand, result and sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_x         <= '0;
         out_y         <= '0;
         spurious_done <= 1'b0;
      end else begin
         if (pop)     acc_x <= mem[rd_ptr];
         if (capture) out_y <= acc_y;
         if (clk_en && acc_done && state != ST_WAIT)
            spurious_done <= 1'b1;
      end
   end

`ifdef ACCEL_DISPATCH_PERF_EN
   // Saturating count of enabled cycles with work queued or in flight.
   always_ff @(posedge clk) begin
      if (reset)
         perf_busy <= '0;
      else if (clk_en && (state != ST_IDLE || in_count != '0) && perf_busy != 32'hFFFF_FFFF)
         perf_busy <= perf_busy + 32'd1;
   end
`endif

endmodule

// File: tb/tb_accel_dispatch.sv
// tb/tb_accel_dispatch.sv - table-driven and directed checks for accel_dispatch
module tb_accel_dispatch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_x = '0;
   logic        in_ready;
   logic        acc_start;
   logic [31:0] acc_x;
   logic        acc_done = 1'b0;
   logic [31:0] acc_y = '0;
   logic        out_valid;
   logic [31:0] out_y;
   logic        out_ready = 1'b0;
   logic [3:0]  in_count;
   logic        spurious_done;
`ifdef ACCEL_DISPATCH_PERF_EN
   logic [31:0] perf_busy;
`endif

   int checks = 0;
   int failures = 0;

   accel_dispatch #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
      .acc_start(acc_start), .acc_x(acc_x), .acc_done(acc_done), .acc_y(acc_y),
      .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready),
      .in_count(in_count), .spurious_done(spurious_done)
`ifdef ACCEL_DISPATCH_PERF_EN
      , .perf_busy(perf_busy)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ce, iv;
      logic [31:0] ix;
      logic        ad;
      logic [31:0] ay;
      logic        ordy;
      logic        e_rdy, e_start;
      logic [31:0] e_ax;
      logic        e_ov;
      logic [31:0] e_oy;
      logic [3:0]  e_cnt;
      logic        e_sp;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic rst, input logic ce, input logic iv, input logic [31:0] ix,
                               input logic ad, input logic [31:0] ay, input logic ordy,
                               input logic e_rdy, input logic e_start, input logic [31:0] e_ax,
                               input logic e_ov, input logic [31:0] e_oy, input logic [3:0] e_cnt,
                               input logic e_sp);
      vec_t v;
      v.rst = rst; v.ce = ce; v.iv = iv; v.ix = ix; v.ad = ad; v.ay = ay; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_start = e_start; v.e_ax = e_ax; v.e_ov = e_ov;
      v.e_oy = e_oy; v.e_cnt = e_cnt; v.e_sp = e_sp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic ce, input logic iv, input logic [31:0] ix,
                       input logic ad, input logic [31:0] ay, input logic ordy);
      reset = rst; clk_en = ce; in_valid = iv; in_x = ix;
      acc_done = ad; acc_y = ay; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic push(input logic [31:0] x);
      step(1'b0, 1'b1, 1'b1, x, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic done(input logic [31:0] y);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, y, 1'b0);
   endtask

   task automatic accept();
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
   endtask

   // Waits (bounded) for the launch of the next job, then completes it with result y.
   task automatic run_job(input logic [31:0] ex, input logic [31:0] y);
      for (int n = 0; n < 20 && acc_start !== 1'b1; n++) idle();
      chk("job_start", 32'(acc_start), 32'd1);
      chk("job_acc_x", acc_x, ex);
      idle();
      done(y);
      chk("job_out_valid", 32'(out_valid), 32'd1);
      chk("job_out_y", out_y, y);
      accept();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] perf_snap;
      perf_snap = '0;

      tbl[0]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0,       1'b0, 1'b1,1'b0,32'h0,       1'b0,32'h0,       4'd0,1'b0);
      tbl[1]  = mk(1'b0,1'b1,1'b1,32'h11111111,1'b0,32'h0,       1'b0, 1'b1,1'b0,32'h0,       1'b0,32'h0,       4'd1,1'b0);
      tbl[2]  = mk(1'b0,1'b1,1'b1,32'h22222222,1'b0,32'h0,       1'b0, 1'b1,1'b1,32'h11111111,1'b0,32'h0,       4'd1,1'b0);
      tbl[3]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,32'hBAD00000,1'b0, 1'b1,1'b0,32'h11111111,1'b0,32'h0,       4'd1,1'b1);
      tbl[4]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,32'hAAAA0001,1'b0, 1'b1,1'b0,32'h11111111,1'b1,32'hAAAA0001,4'd1,1'b1);
      tbl[5]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,32'h55555555,1'b0, 1'b1,1'b0,32'h11111111,1'b1,32'hAAAA0001,4'd1,1'b1);
      tbl[6]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h11111111,1'b0,32'hAAAA0001,4'd1,1'b1);
      tbl[7]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       1'b0, 1'b1,1'b1,32'h22222222,1'b0,32'hAAAA0001,4'd0,1'b1);
      tbl[8]  = mk(1'b0,1'b0,1'b1,32'hEEEEEEEE,1'b0,32'h0,       1'b0, 1'b0,1'b0,32'h22222222,1'b0,32'hAAAA0001,4'd0,1'b1);
      tbl[9]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       1'b0, 1'b1,1'b0,32'h22222222,1'b0,32'hAAAA0001,4'd0,1'b1);
      tbl[10] = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,32'hCCCC0002,1'b0, 1'b1,1'b0,32'h22222222,1'b1,32'hCCCC0002,4'd0,1'b1);
      tbl[11] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       1'b1, 1'b1,1'b0,32'h22222222,1'b0,32'hCCCC0002,4'd0,1'b1);
      tbl[12] = mk(1'b1,1'b0,1'b1,32'h12345678,1'b1,32'h0,       1'b0, 1'b0,1'b0,32'h0,       1'b0,32'h0,       4'd0,1'b0);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst, tbl[i].ce, tbl[i].iv, tbl[i].ix, tbl[i].ad, tbl[i].ay, tbl[i].ordy);
         chk($sformatf("v%0d_in_ready", i),  32'(in_ready),      32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_acc_start", i), 32'(acc_start),     32'(tbl[i].e_start));
         chk($sformatf("v%0d_acc_x", i),     acc_x,              tbl[i].e_ax);
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid),     32'(tbl[i].e_ov));
         chk($sformatf("v%0d_out_y", i),     out_y,              tbl[i].e_oy);
         chk($sformatf("v%0d_in_count", i),  32'(in_count),      32'(tbl[i].e_cnt));
         chk($sformatf("v%0d_spurious", i),  32'(spurious_done), 32'(tbl[i].e_sp));
      end

      // Basic latency with a 20-cycle accelerator.
      do_reset();
      push(32'h3F800000);
      chk("lat_start_e0", 32'(acc_start), 32'd0);
      idle();
      chk("lat_start_e1", 32'(acc_start), 32'd1);
      chk("lat_acc_x", acc_x, 32'h3F800000);
      for (int i = 0; i < 19; i++) idle();
      chk("lat_no_early_valid", 32'(out_valid), 32'd0);
      done(32'h40490FDB);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_out_y", out_y, 32'h40490FDB);
      accept();
      chk("lat_popped", 32'(out_valid), 32'd0);

      // Nine back-to-back pushes against a stalled accelerator, then drain in order.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'd1);
         push(32'h1000 + 32'(i));
      end
      chk("fill_count", 32'(in_count), 32'd8);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      push(32'hFFFF0000);
      chk("full_count", 32'(in_count), 32'd8);
      chk("fill_acc_x", acc_x, 32'h1000);
      done(32'h2000);
      chk("fill_out_y0", out_y, 32'h2000);
      accept();
      for (int k = 1; k < 9; k++) run_job(32'h1000 + 32'(k), 32'h2000 + 32'(k));
      chk("drain_count", 32'(in_count), 32'd0);
      idle(); idle();
      chk("drain_no_start", 32'(acc_start), 32'd0);

      // Downstream back-pressure in HOLD.
      do_reset();
      push(32'h3000);
      idle(); idle();
      done(32'h77777777);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, (i == 0), 32'h3001, 1'b0, 32'h0, 1'b0);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_out_y", out_y, 32'h77777777);
         chk("hold_no_start", 32'(acc_start), 32'd0);
      end
      accept();
      chk("hold_released", 32'(out_valid), 32'd0);
      idle();
      chk("hold_next_start", 32'(acc_start), 32'd1);
      chk("hold_next_x", acc_x, 32'h3001);

      // Stray completion while idle.
      do_reset();
      done(32'hDEADBEEF);
      chk("idle_spurious", 32'(spurious_done), 32'd1);
      chk("idle_out_y", out_y, 32'h0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // Reset while waiting with three samples queued.
      do_reset();
      push(32'h4000); push(32'h4001); push(32'h4002); push(32'h4003);
      chk("rstw_count_pre", 32'(in_count), 32'd3);
      do_reset();
      chk("rstw_count", 32'(in_count), 32'd0);
      chk("rstw_out_valid", 32'(out_valid), 32'd0);
      chk("rstw_acc_x", acc_x, 32'h0);
      done(32'h99999999);
      chk("rstw_spurious", 32'(spurious_done), 32'd1);
      chk("rstw_out_valid2", 32'(out_valid), 32'd0);
      chk("rstw_out_y", out_y, 32'h0);
      idle();
      chk("rstw_no_start", 32'(acc_start), 32'd0);

      // Clock enable low during WAIT with a completion pulse that must be ignored.
      do_reset();
      push(32'h5000); push(32'h5001);
      idle();
`ifdef ACCEL_DISPATCH_PERF_EN
      perf_snap = perf_busy;
`endif
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 32'h5002, (i == 2), 32'h5555AAAA, 1'b1);
         chk("ce_in_ready", 32'(in_ready), 32'd0);
         chk("ce_count", 32'(in_count), 32'd1);
         chk("ce_out_valid", 32'(out_valid), 32'd0);
         chk("ce_no_start", 32'(acc_start), 32'd0);
`ifdef ACCEL_DISPATCH_PERF_EN
         chk("ce_perf", perf_busy, perf_snap);
`endif
      end
      idle();
      chk("ce_still_wait", 32'(out_valid), 32'd0);
      chk("ce_acc_x", acc_x, 32'h5000);
      chk("ce_spurious", 32'(spurious_done), 32'd0);
      done(32'h600DF00D);
      chk("ce_capture", out_y, 32'h600DF00D);
      chk("ce_out_valid2", 32'(out_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
